lsu_bus_bridge: RTL and testbench
=================================

# lsu_bus_bridge

Load/store bridge between the single-cycle core's data-memory port and a word-wide, handshaked system bus. It consumes the core's `address`, `rs2_data`, `fn3`, `mem_read` and `mem_write`, and returns `mem_out`. It also drives a `stall` that freezes the core while a bus transaction is outstanding. Byte-lane steering, load sign/zero extension, alignment checking and a bus timeout are all done here.

## Interface
- `TIMEOUT`, 256: maximum cycles spent in REQ+WAIT_R before the access is aborted; legal range 2..65535.
- `clk` in 1: core clock, rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `mem_read` in 1: core load request, level.
- `mem_write` in 1: core store request, level. `mem_read` and `mem_write` are never both 1.
- `fn3` in 3: RISC-V funct3 of the current load/store.
- `address` in 32: byte address (ALU result).
- `rs2_data` in 32: store data, right-justified.
- `mem_out` out 32: extended load result, registered.
- `stall` out 1: core must hold PC and register write-enable.
- `fault` out 1: one-cycle pulse, access completed with error.
- `fault_code` out 2: cause, valid while `fault`=1.
- `bus_req` out 1: request valid.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word address, `{address[31:2],2'b00}`.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_gnt` in 1: request accepted this cycle.
- `bus_rvalid` in 1: read data valid.
- `bus_rdata` in 32: read data.

## Operation
- FSM states: IDLE, REQ, WAIT_R, DONE.
- **IDLE**
  - On `mem_read|mem_write`, register the command: we, aligned address, be, wdata, byte offset, fn3.
  - If the command is legal, go to REQ. Otherwise go to DONE with a fault latched.
- **Legality**
  - Illegal `fn3` gives fault_code 2'b10: any load fn3 not in {000,001,010,100,101}, or any store fn3 not in {000,001,010}.
  - Misalignment gives fault_code 2'b01: halfword with `address[0]`=1, or word with `address[1:0]`≠0.
- **Store lanes**
  - SB: be=`4'b0001<<address[1:0]`, wdata={4{rs2[7:0]}}.
  - SH: be=`address[1]`?1100:0011, wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
- **Load lanes**
  - Loads always use be=1111.
  - The byte or halfword is selected by the registered offset.
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- **REQ**: `bus_req`=1 with stable fields until `bus_gnt`. On grant, a write goes to DONE and a read goes to WAIT_R.
- **WAIT_R**: on `bus_rvalid`, extend `bus_rdata` into `mem_out`, then go to DONE.
- **Timeout**
  - A 16-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT_R.
  - When it reaches `TIMEOUT-1` without completion, go to DONE with fault_code 2'b11.
  - On timeout, `mem_out` is loaded with 0 for reads.
- **DONE**: `stall`=0. `fault` is asserted if a fault was latched. Next state is unconditionally IDLE.
- **Faulted loads** write 0 to `mem_out`. Faulted stores issue no bus write.
- `bus_rvalid` or `bus_gnt` arriving outside WAIT_R or REQ respectively is ignored. A late response after a timeout is dropped.

## Timing
- Reset values: state IDLE; `mem_out`=0, `stall`=0, `fault`=0, `fault_code`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0; counter=0.
- `stall` is combinational: `(IDLE & (mem_read|mem_write)) | REQ | WAIT_R`. The core therefore retires the instruction in the DONE cycle.
- `bus_req` is registered (decoded from state) and has no combinational path from core inputs.
- Store with immediate grant: C0 IDLE (stall), C1 REQ (stall, gnt), C2 DONE.
- Load with immediate grant and rvalid one cycle later: C0 IDLE, C1 REQ, C2 WAIT_R (rvalid), C3 DONE with `mem_out` valid.
- Minimum stall is 2 cycles for a store and 3 cycles for a load.
- Fault path: C0 IDLE, C1 DONE with `fault`=1 and no `bus_req`.
- `bus_rvalid` in the same cycle as `bus_gnt` is not accepted. Read data must arrive ≥1 cycle after grant.
- `mem_out` holds its value until the next load reaches DONE. Stores do not modify it.
- Asserting `reset` mid-transaction drops `bus_req` asynchronously. No completion or fault is reported for the aborted access.

## Structure
- Package `lsu_pkg`:
  - state enum `lsu_state_e`.
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - fault codes `FLT_NONE`, `FLT_MISALIGN`, `FLT_FN3`, `FLT_TIMEOUT`.
- Sub-module `lsu_lane_align` (combinational) contains store be/wdata generation, load extraction/extension and the legality check. The top holds the FSM, registers and counter.

## Test plan
- SW to 0x100, rs2=0xDEADBEEF, gnt at C1: expect bus_addr=0x100, be=1111, wdata=0xDEADBEEF, stall high C0–C1, low C2, fault=0.
- SB to 0x103, rs2=0x000000A5: expect be=1000, wdata=0xA5A5A5A5.
- LB from 0x202, rdata=0x0080FF00: expect mem_out=0xFFFFFF80. LBU from the same address: expect mem_out=0x00000080.
- LH to 0x201: expect no bus_req, DONE at C1, fault=1, fault_code=01, mem_out=0.
- LW with `bus_gnt` held low, TIMEOUT=8: expect abort after 7 cycles in REQ, fault_code=11, mem_out=0, and a late rvalid ignored.
- Reset asserted while in WAIT_R: expect bus_req=0 and stall=0 immediately, mem_out=0. The next load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus bridge.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_R = 2'b10,
    DONE   = 2'b11
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_FN3      = 2'b10;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store be/wdata, load extract/extend,
// and legality check of the incoming command.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        i_is_store,
  input  logic [2:0]  i_fn3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rs2,
  output logic        o_illegal,
  output logic [1:0]  o_fault_code,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_fn3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic        w_fn3_ok;
  logic        w_misalign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    if (i_is_store) begin
      w_fn3_ok = (i_fn3 == F3_B) || (i_fn3 == F3_H) || (i_fn3 == F3_W);
    end else begin
      w_fn3_ok = (i_fn3 == F3_B) || (i_fn3 == F3_H) || (i_fn3 == F3_W) ||
                 (i_fn3 == F3_BU) || (i_fn3 == F3_HU);
    end
  end

  // fn3[1:0] encodes access size for every legal encoding.
  assign w_misalign = ((i_fn3[1:0] == 2'b01) && i_addr_lo[0]) ||
                      ((i_fn3[1:0] == 2'b10) && (i_addr_lo != 2'b00));

  always_comb begin
    o_fault_code = FLT_NONE;
    if (!w_fn3_ok) begin
      o_fault_code = FLT_FN3;
    end else if (w_misalign) begin
      o_fault_code = FLT_MISALIGN;
    end
  end

  assign o_illegal = (o_fault_code != FLT_NONE);

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = 32'h0;
    if (i_is_store) begin
      case (i_fn3)
        F3_B: begin
          o_be    = 4'b0001 << i_addr_lo;
          o_wdata = {4{i_rs2[7:0]}};
        end
        F3_H: begin
          o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_rs2[15:0]}};
        end
        default: o_wdata = i_rs2;
      endcase
    end
  end

  always_comb begin
    case (i_ld_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_ld_fn3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_data = {24'h0, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_data = {16'h0, w_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Bridges the core data-memory port onto a handshaked word bus; stalls the core
// while an access is outstanding and reports misalignment/fn3/timeout faults.
module lsu_bus_bridge
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  fn3,
  input  logic [31:0] address,
  input  logic [31:0] rs2_data,
  output logic [31:0] mem_out,
  output logic        stall,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  lsu_state_e  r_state;
  lsu_state_e  w_state_nxt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [1:0]  r_off;
  logic [2:0]  r_fn3;
  logic        r_flt;
  logic [1:0]  r_flt_code;
  logic [15:0] r_cnt;
  logic [31:0] r_mem_out;

  logic        w_cmd;
  logic        w_illegal;
  logic [1:0]  w_code;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_data;
  logic        w_tmo;

  assign w_cmd = mem_read | mem_write;
  // Fires on the cycle whose increment would bring the counter to TIMEOUT-1.
  assign w_tmo = ((r_cnt + 16'd1) == TMO_LAST);

  lsu_lane_align u_lane (
    .i_is_store   (mem_write),
    .i_fn3        (fn3),
    .i_addr_lo    (address[1:0]),
    .i_rs2        (rs2_data),
    .o_illegal    (w_illegal),
    .o_fault_code (w_code),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .i_ld_fn3     (r_fn3),
    .i_ld_off     (r_off),
    .i_rdata      (bus_rdata),
    .o_ld_data    (w_ld_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    case (r_state)
      IDLE: begin
        stall = w_cmd;
        if (w_cmd) begin
          w_state_nxt = w_illegal ? DONE : REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_gnt) begin
          w_state_nxt = r_we ? DONE : WAIT_R;
        end else if (w_tmo) begin
          w_state_nxt = DONE;
        end
      end
      WAIT_R: begin
        stall = 1'b1;
        if (bus_rvalid || w_tmo) begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we       <= 1'b0;
      r_addr     <= 32'h0;
      r_be       <= 4'h0;
      r_wdata    <= 32'h0;
      r_off      <= 2'b00;
      r_fn3      <= 3'b000;
      r_flt      <= 1'b0;
      r_flt_code <= FLT_NONE;
      r_cnt      <= 16'h0;
      r_mem_out  <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= 16'h0;
          if (w_cmd) begin
            r_we       <= mem_write;
            r_addr     <= {address[31:2], 2'b00};
            r_be       <= w_be;
            r_wdata    <= w_wdata;
            r_off      <= address[1:0];
            r_fn3      <= fn3;
            r_flt      <= w_illegal;
            r_flt_code <= w_code;
            if (w_illegal && mem_read) begin
              r_mem_out <= 32'h0;
            end
          end
        end
        REQ: begin
          r_cnt <= r_cnt + 16'd1;
          if (!bus_gnt && w_tmo) begin
            r_flt      <= 1'b1;
            r_flt_code <= FLT_TIMEOUT;
            if (!r_we) begin
              r_mem_out <= 32'h0;
            end
          end
        end
        WAIT_R: begin
          r_cnt <= r_cnt + 16'd1;
          if (bus_rvalid) begin
            r_mem_out <= w_ld_data;
          end else if (w_tmo) begin
            r_flt      <= 1'b1;
            r_flt_code <= FLT_TIMEOUT;
            r_mem_out  <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_out    = r_mem_out;
  assign fault      = (r_state == DONE) && r_flt;
  assign fault_code = fault ? r_flt_code : FLT_NONE;
  assign bus_req    = (r_state == REQ);
  assign bus_we     = r_we;
  assign bus_addr   = r_addr;
  assign bus_be     = r_be;
  assign bus_wdata  = r_wdata;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Scoreboard bench for lsu_bus_bridge: driver pushes expectations from a
// size/offset reference model, a monitor checks bus beats and completions.
module tb_lsu_bus_bridge;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  fn3 = 3'b000;
  logic [31:0] address = 32'h0;
  logic [31:0] rs2_data = 32'h0;
  logic [31:0] mem_out;
  logic        stall;
  logic        fault;
  logic [1:0]  fault_code;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  always #5 clk = ~clk;

  lsu_bus_bridge #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .fn3(fn3), .address(address), .rs2_data(rs2_data), .mem_out(mem_out),
    .stall(stall), .fault(fault), .fault_code(fault_code), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        fault;
    logic [1:0]  code;
    logic [31:0] mem_out;
    int          stall_cyc;
  } done_exp_t;

  bus_exp_t    bus_q[$];
  done_exp_t   done_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_mem = 32'h0;
  int          cfg_g = 0;
  int          cfg_r = 1;
  logic [31:0] cfg_rdata = 32'h0;
  logic        resp_flush = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Access size in bytes (0 = illegal encoding) and signedness from funct3.
  function automatic void decode(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                 output int n, output logic sgn, output logic [1:0] code);
    n = 0;
    sgn = 1'b0;
    case (f3)
      3'd0: begin n = 1; sgn = 1'b1; end
      3'd1: begin n = 2; sgn = 1'b1; end
      3'd2: n = 4;
      3'd4: if (!st) n = 1;
      3'd5: if (!st) n = 2;
      default: n = 0;
    endcase
    if (n == 0) code = 2'b10;
    else if ((int'(a[1:0]) % n) != 0) code = 2'b01;
    else code = 2'b00;
  endfunction

  function automatic logic [31:0] ld_val(input logic [31:0] rd, input int off, input int n,
                                         input logic sgn);
    logic [31:0] mask;
    logic [31:0] v;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v = (rd >> (8 * off)) & mask;
    if (sgn && (n < 4) && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic start(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] rs2, input logic [31:0] rd, input int g, input int r);
    int        n;
    logic      sgn;
    logic [1:0] code;
    int        idx;
    int        busy;
    logic [3:0] lanes;
    bus_exp_t  b;
    done_exp_t d;
    decode(st, f3, a, n, sgn, code);
    busy    = 0;
    d.fault = (code != 2'b00);
    d.code  = code;
    if (code != 2'b00) begin
      if (!st) exp_mem = 32'h0;
    end else begin
      idx = st ? g : g + r;
      if (g <= T - 2) begin
        lanes   = 4'((32'd1 << n) - 32'd1);
        b.we    = st;
        b.addr  = {a[31:2], 2'b00};
        b.be    = st ? (lanes << a[1:0]) : 4'hF;
        b.wdata = (n == 1) ? {24'h0, rs2[7:0]} * 32'h0101_0101 :
                  (n == 2) ? {16'h0, rs2[15:0]} * 32'h0001_0001 : rs2;
        bus_q.push_back(b);
      end
      if (idx <= T - 2) begin
        busy = idx + 1;
        if (!st) exp_mem = ld_val(rd, int'(a[1:0]), n, sgn);
      end else begin
        busy    = T - 1;
        d.fault = 1'b1;
        d.code  = 2'b11;
        if (!st) exp_mem = 32'h0;
      end
    end
    d.mem_out   = exp_mem;
    d.stall_cyc = busy + 1;
    done_q.push_back(d);
    cfg_g     = (code != 2'b00) ? 0 : g;
    cfg_r     = r;
    cfg_rdata = rd;
    mem_read  = !st;
    mem_write = st;
    fn3       = f3;
    address   = a;
    rs2_data  = rs2;
  endtask

  task automatic finish_txn();
    int cyc;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (stall && cyc < 50);
    chk("done_within_bound", 32'(cyc < 50), 32'd1);
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] rs2, input logic [31:0] rd, input int g, input int r);
    start(st, f3, a, rs2, rd, g, r);
    finish_txn();
  endtask

  // Bus slave: grants after cfg_g request cycles, returns data cfg_r cycles later,
  // and throws junk rvalid alongside every grant.
  initial begin
    int req_cyc;
    int rv_cnt;
    req_cyc = 0;
    rv_cnt  = 0;
    forever begin
      @(posedge clk); #2;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = $urandom;
      if (resp_flush) begin
        req_cyc = 0;
        rv_cnt  = 0;
      end else begin
        if (rv_cnt > 0) begin
          rv_cnt--;
          if (rv_cnt == 0) begin
            bus_rvalid = 1'b1;
            bus_rdata  = cfg_rdata;
          end
        end
        if (bus_req) begin
          if (req_cyc == cfg_g) begin
            bus_gnt    = 1'b1;
            bus_rvalid = 1'b1;
            if (!bus_we) rv_cnt = cfg_r;
          end
          req_cyc++;
        end else begin
          req_cyc = 0;
        end
      end
    end
  end

  initial begin
    logic      prev_stall;
    int        run;
    bus_exp_t  b;
    done_exp_t d;
    prev_stall = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
        run = 0;
        bus_q.delete();
        done_q.delete();
      end else begin
        if (bus_req && bus_gnt) begin
          if (bus_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_bus_req: addr %h, no request expected", bus_addr);
          end else begin
            b = bus_q.pop_front();
            chk("bus_we", 32'(bus_we), 32'(b.we));
            chk("bus_addr", bus_addr, b.addr);
            chk("bus_be", 32'(bus_be), 32'(b.be));
            if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
          end
        end
        if (stall) begin
          run++;
          chk("fault_while_stalled", 32'(fault), 32'd0);
        end else if (prev_stall) begin
          if (done_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_completion: got fault %b, no access expected", fault);
          end else begin
            d = done_q.pop_front();
            chk("fault", 32'(fault), 32'(d.fault));
            if (d.fault) chk("fault_code", 32'(fault_code), 32'(d.code));
            chk("mem_out", mem_out, d.mem_out);
            chk("stall_cycles", 32'(run), 32'(d.stall_cyc));
          end
          run = 0;
        end else begin
          chk("fault_idle", 32'(fault), 32'd0);
        end
        prev_stall = stall;
      end
    end
  end

  initial begin
    logic [2:0]  ld_f3 [5];
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          p;
    int          g;
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    #1;
    chk("rst_mem_out", mem_out, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_code", 32'(fault_code), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    resp_flush = 1'b0;
    @(posedge clk); #1;

    txn(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 1);
    txn(1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 1);
    txn(1'b0, 3'd0, 32'h0000_0202, 32'h0, 32'h0080_FF00, 0, 1);
    txn(1'b0, 3'd4, 32'h0000_0202, 32'h0, 32'h0080_FF00, 0, 1);
    txn(1'b0, 3'd1, 32'h0000_0201, 32'h0, 32'h1234_5678, 0, 1);
    txn(1'b0, 3'd2, 32'h0000_0204, 32'h0, 32'h1234_5678, 1, 2);
    txn(1'b0, 3'd2, 32'h0000_0300, 32'h0, 32'h5555_AAAA, 255, 1);
    txn(1'b0, 3'd5, 32'h0000_0306, 32'h0, 32'h8001_7FFF, 3, 3);
    txn(1'b0, 3'd2, 32'h0000_0308, 32'h0, 32'hCAFE_F00D, 1, 6);
    txn(1'b1, 3'd1, 32'h0000_0402, 32'h0000_BEEF, 32'h0, 2, 1);
    txn(1'b1, 3'd1, 32'h0000_0401, 32'h0000_BEEF, 32'h0, 0, 1);
    txn(1'b1, 3'd4, 32'h0000_0400, 32'h0000_BEEF, 32'h0, 0, 1);
    txn(1'b0, 3'd3, 32'h0000_0400, 32'h0, 32'h0, 0, 1);
    txn(1'b0, 3'd1, 32'h0000_0502, 32'h0, 32'h8765_4321, 0, 1);

    // Abort an in-flight load with reset.
    start(1'b0, 3'd2, 32'h0000_0600, 32'h0, 32'h1111_2222, 0, 20);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_stall", 32'(stall), 32'd1);
    reset = 1'b0;
    mem_read = 1'b0;
    resp_flush = 1'b1;
    #1;
    chk("mid_reset_bus_req", 32'(bus_req), 32'd0);
    chk("mid_reset_stall", 32'(stall), 32'd0);
    chk("mid_reset_mem_out", mem_out, 32'h0);
    chk("mid_reset_fault", 32'(fault), 32'd0);
    exp_mem = 32'h0;
    @(posedge clk); #1;
    reset = 1'b1;
    resp_flush = 1'b0;
    @(posedge clk); #1;
    txn(1'b0, 3'd2, 32'h0000_0604, 32'h0, 32'h3333_4444, 0, 1);

    for (int i = 0; i < 150; i++) begin
      st = 1'($urandom_range(0, 1));
      p  = $urandom_range(0, 9);
      if (p == 9) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else f3 = ld_f3[$urandom_range(0, 4)];
      a = $urandom;
      if (p < 7 && f3[1:0] == 2'b10) a[1:0] = 2'b00;
      if (p < 7 && f3[1:0] == 2'b01) a[0] = 1'b0;
      g = ($urandom_range(0, 19) == 0) ? 255 : $urandom_range(0, 3);
      txn(st, f3, a, $urandom, $urandom, g, $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
